// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings a PLL out of reset, waits for a stable lock, and only then releases
// the downstream core reset. A lock that never arrives is retried a bounded
// number of times before the block parks in FAIL. Lock loss while running
// triggers a full PLL re-sequence.
//
// Parameters
//   RST_CYCLES    : cycles pll_rst is held high per attempt        (1..65535)
//   LOCK_TIMEOUT  : cycles allowed in WAIT_LOCK before a retry     (1..2^24-1)
//   STABLE_CYCLES : consecutive locked cycles required before RUN  (1..65535)
//   MAX_RETRIES   : consecutive timeouts tolerated before FAIL     (1..15)
//
// Ports
//   refclk      in   sole clock (PLL reference)
//   rst_n       in   synchronous active-low reset
//   pll_locked  in   PLL lock flag, asynchronous to refclk
//   restart     in   single-cycle request for a full re-sequence
//   pll_rst     out  active-high PLL reset
//   core_reset  out  active-high downstream reset, high outside RUN
//   ready       out  high only in RUN
//   fail        out  high only in FAIL
//   retry_count out  consecutive lock timeouts since last success (sat. 15)
//
// State table
//   state        | meaning
//   -------------+-------------------------------------------------------------
//   PLL_RST      | pll_rst asserted, counting RST_CYCLES
//   WAIT_LOCK    | pll_rst released, waiting for lock_s or timeout
//   STABLE       | lock_s seen, counting consecutive locked cycles
//   RUN          | lock stable, core released, ready asserted
//   FAIL         | retries exhausted, parked until rst_n or restart
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Terminal-count values: the counter starts at 0 on state entry, so the
    // last cycle of an N-cycle interval sees count N-1.
    localparam logic [23:0] RST_TC      = 24'(RST_CYCLES - 1);
    localparam logic [23:0] LOCK_TC     = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] STABLE_TC   = 24'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam logic [23:0] CNT_MAX     = 24'hFF_FFFF;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        sync1_q, sync1_d;
    logic        lock_s_q, lock_s_d;
    logic        pll_rst_q, pll_rst_d;
    logic        core_reset_q, core_reset_d;
    logic        ready_q, ready_d;
    logic        fail_q, fail_d;

    logic [23:0] cnt_inc;
    logic [3:0]  retry_inc;

    // Saturating increments: neither the cycle counter nor the retry count
    // may wrap.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 24'd1;
    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    // Two-flop synchronizer for the asynchronous lock flag.
    assign sync1_d  = pll_locked;
    assign lock_s_d = sync1_q;

    // -------------------------------------------------------------------------
    // State register (plus counter, retry count, synchronizer, outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            retry_q      <= '0;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            sync1_q      <= sync1_d;
            lock_s_q     <= lock_s_d;
            pll_rst_q    <= pll_rst_d;
            core_reset_q <= core_reset_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        retry_d = retry_q;

        // restart overrides every other transition, including a coincident
        // timeout or lock loss.
        if (restart) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == RST_TC) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LOCK_TC) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                    end
                end

                ST_STABLE: begin
                    if (!lock_s_q) begin
                        // A glitch only restarts the stability window; the
                        // PLL itself is not reset and retries are untouched.
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_TC) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end

                ST_RUN: begin
                    cnt_d = cnt_q;
                    if (!lock_s_q) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                    end
                end

                ST_FAIL: begin
                    cnt_d = cnt_q;
                end

                default: begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: decoded from the next state so the registered outputs
    // line up with the state they describe. core_reset is high in every state
    // where pll_rst can be high, so the core never runs on a resetting PLL.
    // -------------------------------------------------------------------------
    always_comb begin
        pll_rst_d    = (state_d == ST_PLL_RST);
        core_reset_d = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        fail_d       = (state_d == ST_FAIL);
    end

    assign pll_rst     = pll_rst_q;
    assign core_reset  = core_reset_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Drives pll_reset_sequencer with directed scenarios followed by randomized
// lock/restart/reset traffic. A phase-level reference model (phase name,
// cycles elapsed in the phase, retry tally, and a two-deep lock history
// queue standing in for the synchronizer) predicts every output each cycle.
// Directed scenarios additionally pin hand-computed edge numbers.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int RST_C    = 4;
    localparam int LOCK_TO  = 20;
    localparam int STABLE_C = 8;
    localparam int MAX_R    = 3;

    localparam int PH_PLLRST = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (LOCK_TO),
        .STABLE_CYCLES(STABLE_C),
        .MAX_RETRIES  (MAX_R)
    ) dut (
        .refclk     (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .core_reset (core_reset),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count)
    );

    initial forever #5 clk = ~clk;

    // Reference model state
    int ph;
    int el;
    int rt;
    bit mvalid = 1'b0;
    bit lock_q[$];

    int checks = 0;
    int errors = 0;
    int k;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs the DUT sees.
    task automatic model_step();
        bit ls;
        if (!rst_n) begin
            ph     = PH_PLLRST;
            el     = 0;
            rt     = 0;
            lock_q = '{1'b0, 1'b0};
            mvalid = 1'b1;
            return;
        end
        // Decisions use the lock value sampled two edges earlier.
        ls = lock_q.pop_front();
        lock_q.push_back(pll_locked);
        if (restart) begin
            ph = PH_PLLRST;
            el = 0;
            rt = 0;
            return;
        end
        case (ph)
            PH_PLLRST: begin
                el++;
                if (el == RST_C) begin
                    ph = PH_WAIT;
                    el = 0;
                end
            end
            PH_WAIT: begin
                if (ls) begin
                    ph = PH_STABLE;
                    el = 0;
                end else begin
                    el++;
                    if (el == LOCK_TO) begin
                        rt = (rt < 15) ? rt + 1 : 15;
                        ph = (rt == MAX_R) ? PH_FAIL : PH_PLLRST;
                        el = 0;
                    end
                end
            end
            PH_STABLE: begin
                if (!ls) begin
                    ph = PH_WAIT;
                    el = 0;
                end else begin
                    el++;
                    if (el == STABLE_C) begin
                        ph = PH_RUN;
                        el = 0;
                        rt = 0;
                    end
                end
            end
            PH_RUN: begin
                if (!ls) begin
                    ph = PH_PLLRST;
                    el = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Advance one cycle: model follows the active edge, outputs are compared
    // on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (mvalid) begin
            chk("pll_rst",     int'(pll_rst),     int'(ph == PH_PLLRST));
            chk("core_reset",  int'(core_reset),  int'(ph != PH_RUN));
            chk("ready",       int'(ready),       int'(ph == PH_RUN));
            chk("fail",        int'(fail),        int'(ph == PH_FAIL));
            chk("retry_count", int'(retry_count), rt);
            chk("core_released_in_pll_rst", int'(pll_rst & ~core_reset), 0);
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            tick();
            k++;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        restart = 1'b0;
        tick();
        tick();
        chk("rst_pll_rst",    int'(pll_rst),     1);
        chk("rst_core_reset", int'(core_reset),  1);
        chk("rst_ready",      int'(ready),       0);
        chk("rst_fail",       int'(fail),        0);
        chk("rst_retry",      int'(retry_count), 0);
        rst_n = 1'b1;
        k     = 0;
    endtask

    initial begin
        int n;
        int prev;
        int pulses;
        int seq;
        int hold;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;

        // Nominal bring-up, then lock loss in RUN
        do_reset();
        n = int'(pll_rst);
        while (k < 10) begin
            tick();
            k++;
            n += int'(pll_rst);
        end
        pll_locked = 1'b1;
        while (!ready && k < 60) begin
            tick();
            k++;
            n += int'(pll_rst);
        end
        chk("nom_ready_edge", k, 21);
        chk("nom_pll_rst_cycles", n, 4);
        chk("nom_retry", int'(retry_count), 0);

        run_to(30);
        pll_locked = 1'b0;
        while (!core_reset && k < 60) begin
            tick();
            k++;
        end
        chk("loss_core_reset_edge", k, 33);
        chk("loss_ready", int'(ready), 0);
        n = int'(pll_rst);
        repeat (12) begin
            tick();
            k++;
            n += int'(pll_rst);
        end
        chk("loss_pll_rst_cycles", n, 4);

        // Repeated timeouts into FAIL
        do_reset();
        prev   = int'(pll_rst);
        pulses = int'(pll_rst);
        seq    = 0;
        n      = 0;
        while (!fail && k < 200) begin
            tick();
            k++;
            if (pll_rst && prev == 0) pulses++;
            prev = int'(pll_rst);
            if (int'(retry_count) != n) begin
                seq = (seq << 4) | int'(retry_count);
                n   = int'(retry_count);
            end
        end
        chk("to_fail_edge", k, 72);
        chk("to_pll_rst_pulses", pulses, 3);
        chk("to_retry_steps", seq, 'h123);
        chk("to_fail_pll_rst", int'(pll_rst), 0);
        repeat (40) tick();
        chk("to_fail_held", int'(fail), 1);
        chk("to_fail_core_reset", int'(core_reset), 1);

        // Restart coincident with the third timeout, then restart out of FAIL
        do_reset();
        run_to(71);
        chk("rs_retry_before", int'(retry_count), 2);
        restart = 1'b1;
        run_to(72);
        restart = 1'b0;
        chk("rs_pll_rst", int'(pll_rst), 1);
        chk("rs_retry_cleared", int'(retry_count), 0);
        chk("rs_no_fail", int'(fail), 0);
        while (!fail && k < 250) begin
            tick();
            k++;
        end
        chk("rs_fail_edge", k, 144);
        run_to(149);
        restart = 1'b1;
        run_to(150);
        restart = 1'b0;
        chk("rs_fail_exit", int'(fail), 0);
        chk("rs_fail_exit_pll_rst", int'(pll_rst), 1);
        chk("rs_fail_exit_retry", int'(retry_count), 0);

        // One-cycle lock glitch during STABLE
        do_reset();
        pll_locked = 1'b0;
        run_to(10);
        pll_locked = 1'b1;
        run_to(17);
        pll_locked = 1'b0;
        run_to(18);
        pll_locked = 1'b1;
        n = 0;
        while (!ready && k < 80) begin
            tick();
            k++;
            n += int'(pll_rst);
        end
        chk("glitch_ready_edge", k, 29);
        chk("glitch_no_pll_rst", n, 0);

        // Reset asserted mid-STABLE
        do_reset();
        run_to(10);
        pll_locked = 1'b1;
        run_to(15);
        rst_n = 1'b0;
        tick();
        chk("midrst_pll_rst", int'(pll_rst), 1);
        chk("midrst_core_reset", int'(core_reset), 1);
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_fail", int'(fail), 0);
        chk("midrst_retry", int'(retry_count), 0);
        rst_n = 1'b1;
        k = 0;
        while (!ready && k < 60) begin
            tick();
            k++;
        end
        chk("midrst_ready_edge", k, 13);

        // Randomized traffic against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            restart = ($urandom_range(0, 149) == 0);
            rst_n   = !($urandom_range(0, 399) == 0);
            if (hold == 0) begin
                pll_locked = !pll_locked;
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                   : int'($urandom_range(5, 150));
            end else begin
                hold--;
            end
            tick();
        end
        restart = 1'b0;
        rst_n   = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles pll_rst is held high per attempt (range 1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry (range 1..2^24-1).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before core release (range 1..65535).
REQ-004 SHALL have parameter MAX_RETRIES, default 7: consecutive timeouts tolerated before FAIL (range 1..15).
REQ-005 SHALL have port refclk, input, 1: sole clock, 50 MHz PLL reference.
REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL locked flag, asynchronous to refclk.
REQ-008 SHALL have port restart, input, 1: single-cycle request to force a full PLL re-sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset driven to the PLL.
REQ-010 SHALL have port core_reset, output, 1: active-high reset for downstream logic; high whenever not in RUN.
REQ-011 SHALL have port ready, output, 1: high only in RUN.
REQ-012 SHALL have port fail, output, 1: high only in FAIL.
REQ-013 SHALL have port retry_count, output, 4: consecutive lock timeouts since last success, saturating at 15.

Function
REQ-014 SHALL synchronize pll_locked through a 2-flop chain; lock_s is the second flop output, and all decisions use lock_s only.
REQ-015 SHALL implement states PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL, encoded one state per cycle with registered outputs.
REQ-016 PLL_RST: pll_rst=1; a cycle counter runs from 0; after exactly RST_CYCLES cycles in the state, the block SHALL go to WAIT_LOCK with the counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; lock_s=1 SHALL go to STABLE next cycle; otherwise, when the counter reaches LOCK_TIMEOUT-1 without lock, the block SHALL increment retry_count (saturating) and go to PLL_RST, or to FAIL if the incremented count equals MAX_RETRIES.
REQ-018 STABLE: lock_s=0 on any cycle SHALL return to WAIT_LOCK with the counter cleared and retry_count unchanged; STABLE_CYCLES consecutive lock_s=1 cycles SHALL go to RUN.
REQ-019 Entry to RUN SHALL clear retry_count to 0 in the same cycle ready rises.
REQ-020 RUN: core_reset=0 and ready=1; lock_s=0 SHALL force core_reset=1 and ready=0 on the next cycle and enter PLL_RST (lock loss is treated as requiring a full PLL reset).
REQ-021 FAIL: pll_rst=0, core_reset=1, fail=1; FAIL SHALL be held until rst_n=0 or restart=1.
REQ-022 restart=1 in any state SHALL enter PLL_RST next cycle with the counter cleared and retry_count cleared; restart has priority over every other transition, including timeout and lock loss on the same cycle.
REQ-023 The cycle counter SHALL be 24 bits wide, SHALL be cleared on every state change, and SHALL NOT wrap within any state.
REQ-024 core_reset SHALL never be 0 while pll_rst is 1.

Reset
REQ-025 While rst_n=0 at a refclk edge, the block SHALL load state=PLL_RST, pll_rst=1, core_reset=1, ready=0, fail=0, retry_count=0, counter=0, and sync flops=0.
REQ-026 The first cycle after rst_n rises SHALL count as PLL_RST cycle 0; rst_n assertion mid-sequence SHALL abort the sequence with no residual state.

Verification
REQ-027 Nominal: RST_CYCLES=4, STABLE_CYCLES=8; pll_locked rises 10 cycles after reset release and stays high -> pll_rst high for exactly 4 cycles, ready=1 after 2 synchronizer cycles plus 8 STABLE cycles, retry_count=0.
REQ-028 Timeout/fail: LOCK_TIMEOUT=20, MAX_RETRIES=3, pll_locked held 0 -> three PLL_RST pulses, retry_count steps 1,2,3, then fail=1, pll_rst=0, and core_reset=1 held indefinitely.
REQ-029 Glitch in STABLE: lock dropped for 1 cycle at STABLE cycle 5 -> return to WAIT_LOCK, no PLL_RST pulse, RUN reached only after a fresh 8-cycle stable run.
REQ-030 Lock loss in RUN: pll_locked falls -> core_reset=1 and ready=0 within 3 cycles of the input edge (2 sync + 1), then a full pll_rst pulse of RST_CYCLES.
REQ-031 Restart priority: restart=1 on the same cycle as a WAIT_LOCK timeout with retry_count=2 -> PLL_RST entered, retry_count=0, no FAIL; restart=1 in FAIL -> PLL_RST and fail=0 next cycle.
REQ-032 Reset mid-STABLE: rst_n low for 1 cycle -> all outputs at reset values on the next cycle and the sequence restarts from PLL_RST.
